// File: rtl/i2c_block_sequencer.sv
// Block transfer sequencer between a local byte RAM and an I2C register-mode master.
// Handles NACK retry with restart from the base address, and aborts on command change.
module i2c_block_sequencer #(
   parameter int ADDR_W    = 5,
   parameter int MAX_RETRY = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   input  logic              mode,
   input  logic [6:0]        slave_addr,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   output logic              m_go,
   output logic              m_stop,
   output logic              m_rw,
   output logic [ADDR_W:0]   m_num_bytes,
   output logic [6:0]        m_slave_addr,
   output logic [ADDR_W-1:0] m_reg_addr,
   output logic [7:0]        m_wdata,
   input  logic              m_done,
   input  logic              m_ready,
   input  logic              m_ack,
   input  logic [7:0]        m_rdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        retries
);

   // state     | meaning
   // IDLE      | waiting for start while the master reports m_done
   // SETUP     | load master command and addresses from the latched request
   // GO        | m_go pulse to the master
   // WAIT_BYTE | waiting for the master to finish a byte (ACK or NACK)
   // NEXT      | count the byte, wait for m_ready low, advance addresses
   // ABORT     | m_stop pulse after a command change mid-transfer
   // DONE      | transfer complete, done held high
   // ERROR     | retries exhausted, error held high
   typedef enum logic [2:0] {IDLE, SETUP, GO, WAIT_BYTE, NEXT, ABORT, DONE, ERROR} state_t;

   localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic                mode_q, mode_d;
   logic [6:0]          saddr_q, saddr_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     remain_q, remain_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
   logic [7:0]          m_wdata_q, m_wdata_d;
   logic [7:0]          ram_wdata_q, ram_wdata_d;
   logic                ram_we_q, ram_we_d;
   logic                m_go_q, m_go_d;
   logic                m_stop_q, m_stop_d;
   logic                m_rw_q, m_rw_d;
   logic [ADDR_W:0]     m_num_q, m_num_d;
   logic [6:0]          m_saddr_q, m_saddr_d;
   logic [1:0]          retries_q, retries_d;
   logic                active;
   logic                changed;

   assign active  = (state_q == SETUP) || (state_q == GO) ||
                    (state_q == WAIT_BYTE) || (state_q == NEXT);
   assign changed = active && ((mode != mode_q) || (slave_addr != saddr_q));

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      saddr_d     = saddr_q;
      base_d      = base_q;
      len_d       = len_q;
      remain_d    = remain_q;
      ram_addr_d  = ram_addr_q;
      reg_addr_d  = reg_addr_q;
      m_wdata_d   = m_wdata_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      m_go_d      = 1'b0;
      m_stop_d    = 1'b0;
      m_rw_d      = m_rw_q;
      m_num_d     = m_num_q;
      m_saddr_d   = m_saddr_q;
      retries_d   = retries_q;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start && m_done) begin
               mode_d    = mode;
               saddr_d   = slave_addr;
               base_d    = base_addr;
               len_d     = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;
               retries_d = 2'd0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            m_rw_d     = mode_q;
            m_num_d    = len_q;
            m_saddr_d  = saddr_q;
            ram_addr_d = base_q;
            reg_addr_d = base_q;
            remain_d   = len_q;
            m_go_d     = 1'b1;
            state_d    = GO;
         end
         GO: state_d = WAIT_BYTE;
         WAIT_BYTE: begin
            if (m_ready) begin
               if (m_ack) begin
                  if (!mode_q) begin
                     m_wdata_d = ram_rdata;
                  end else begin
                     ram_wdata_d = m_rdata;
                     ram_we_d    = 1'b1;
                  end
                  state_d = NEXT;
               end else begin
                  m_stop_d = 1'b1;
                  if (int'(retries_q) < MAX_RETRY) begin
                     retries_d = retries_q + 2'd1;
                     state_d   = SETUP;
                  end else begin
                     state_d = ERROR;
                  end
               end
            end
         end
         NEXT: begin
            if (remain_q == ONE_LEN) begin
               remain_d = '0;
               state_d  = DONE;
            end else if (!m_ready) begin
               remain_d   = remain_q - ONE_LEN;
               ram_addr_d = ram_addr_q + 1'b1;
               reg_addr_d = reg_addr_q + 1'b1;
               state_d    = WAIT_BYTE;
            end
         end
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A command change overrides everything else this cycle, including NACK handling.
      if (changed) begin
         state_d  = ABORT;
         m_stop_d = 1'b1;
         m_go_d   = 1'b0;
         ram_we_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         saddr_q     <= '0;
         base_q      <= '0;
         len_q       <= '0;
         remain_q    <= '0;
         ram_addr_q  <= '0;
         reg_addr_q  <= '0;
         m_wdata_q   <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
         m_go_q      <= 1'b0;
         m_stop_q    <= 1'b0;
         m_rw_q      <= 1'b0;
         m_num_q     <= '0;
         m_saddr_q   <= '0;
         retries_q   <= '0;
      end else if (enable) begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         saddr_q     <= saddr_d;
         base_q      <= base_d;
         len_q       <= len_d;
         remain_q    <= remain_d;
         ram_addr_q  <= ram_addr_d;
         reg_addr_q  <= reg_addr_d;
         m_wdata_q   <= m_wdata_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
         m_go_q      <= m_go_d;
         m_stop_q    <= m_stop_d;
         m_rw_q      <= m_rw_d;
         m_num_q     <= m_num_d;
         m_saddr_q   <= m_saddr_d;
         retries_q   <= retries_d;
      end
   end

   assign ram_addr     = ram_addr_q;
   assign ram_wdata    = ram_wdata_q;
   assign ram_we       = ram_we_q;
   assign m_go         = m_go_q;
   assign m_stop       = m_stop_q;
   assign m_rw         = m_rw_q;
   assign m_num_bytes  = m_num_q;
   assign m_slave_addr = m_saddr_q;
   assign m_reg_addr   = reg_addr_q;
   assign m_wdata      = m_wdata_q;
   assign retries      = retries_q;
   assign busy         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
   assign done         = (state_q == DONE);
   assign error        = (state_q == ERROR);

endmodule

// File: doc/i2c_block_sequencer.md
I2C_BLOCK_SEQUENCER -- requirements
Module: i2c_block_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, local RAM / slave register address width.
REQ-002 SHALL have parameter MAX_RETRY, default 3, NACK retries before error (0 = none).
REQ-003 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset): reset synchronous, active-high; clock clk.
REQ-004 SHALL have ports:
- enable in 1: gate; all state frozen when low.
- start in 1: begin transfer, sampled in IDLE.
- mode in 1: 0 = local RAM -> slave, 1 = slave -> local RAM.
- slave_addr in 7: 7-bit device address.
- base_addr in ADDR_W: first register / RAM address.
- len in ADDR_W+1: byte count, 1..2^ADDR_W.
- ram_addr out ADDR_W: local RAM address.
- ram_rdata in 8: local RAM read data, combinational from ram_addr.
- ram_wdata out 8 / ram_we out 1: local RAM write data and strobe.
- m_go out 1, m_stop out 1: master start and stop pulses.
- m_rw out 1, m_num_bytes out ADDR_W+1, m_slave_addr out 7, m_reg_addr out ADDR_W: master command.
- m_wdata out 8: byte to master.
- m_done, m_ready, m_ack in 1, m_rdata in 8: master status and read data.
- busy, done, error out 1; retries out 2: status.

Function
REQ-005 SHALL implement states IDLE, SETUP, GO, WAIT_BYTE, NEXT, ABORT, DONE, ERROR.
REQ-006 IDLE: start=1 and m_done=1 SHALL latch mode, slave_addr, base_addr and len, clear retries, and go to SETUP next cycle; start while m_done=0 SHALL be ignored.
REQ-007 SETUP SHALL drive m_rw=mode, m_num_bytes=len, m_slave_addr=latched address, ram_addr=m_reg_addr=base_addr, then go to GO.
REQ-008 GO SHALL assert m_go for exactly one cycle, then go to WAIT_BYTE.
REQ-009 WAIT_BYTE with m_ready=1 and m_ack=1: in mode 0 SHALL register m_wdata<=ram_rdata; in mode 1 SHALL set ram_wdata<=m_rdata with ram_we high for exactly one cycle; then go to NEXT.
REQ-010 NEXT SHALL decrement the remaining count; at 0 SHALL go to DONE; otherwise SHALL wait for m_ready=0, then increment ram_addr and m_reg_addr by 1 (modulo 2^ADDR_W wrap) and return to WAIT_BYTE.
REQ-011 WAIT_BYTE with m_ready=1 and m_ack=0 (NACK) SHALL pulse m_stop for one cycle; if retries<MAX_RETRY, retries+1 and go to SETUP, restarting from base_addr with the full len; else go to ERROR.
REQ-012 A mode or slave_addr change versus the latched values while busy SHALL go to ABORT: m_stop pulse for one cycle, then IDLE, with done=0 and error=0.
REQ-013 DONE SHALL hold done=1 until the next accepted start; ERROR SHALL hold error=1 until the next accepted start.
REQ-014 busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-015 len=0 SHALL be treated as 2^ADDR_W; len>2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-016 m_go and m_stop SHALL never be high in the same cycle; ABORT SHALL take precedence over NACK handling in the same cycle.
REQ-017 ram_we SHALL never assert in mode 0.

Reset
REQ-018 Reset SHALL force IDLE and set all outputs to 0, including the registered m_* outputs, ram_addr, ram_wdata and retries, regardless of enable.
REQ-019 Reset mid-transfer SHALL not emit m_stop; a stop to an active master is the system's responsibility.

Verification
REQ-020 Write, base 0, len 32, all ACK, ram[i]=i -> m_go once; m_wdata sequence 0..31; done=1; ram_we never 1.
REQ-021 Read, base 30, len 4, m_rdata=A0..A3 -> ram writes at 30, 31, 0, 1 (wrap); m_reg_addr sequence 30, 31, 0, 1; done=1.
REQ-022 Write, NACK on byte 2 once -> one m_stop, retries=1, m_go again with reg_addr=base, done=1.
REQ-023 Persistent NACK, MAX_RETRY=3 -> 4 m_go pulses, 4 m_stop pulses, error=1, retries=3.
REQ-024 Mode toggle during byte 5 -> one-cycle m_stop, IDLE, busy=0, done=0, error=0.
REQ-025 Reset asserted in WAIT_BYTE -> next cycle all outputs 0, state IDLE; start with m_done=0 -> no m_go.
